// File: rtl/framebuffer_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_writer_if
// Purpose  : Received-byte stream and framebuffer write-port bundle for the
//            framebuffer writer (slave = writer, master = its environment).
// Revision : 1.0 - initial release
// ============================================================================
interface framebuffer_writer_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            rx_data;
    logic                  rx_strobe;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_data;
    logic                  ram_wr;
    logic                  busy;
    logic                  frame_done;
    logic                  error;

    modport master (
        output rx_data,
        output rx_strobe,
        input  ram_addr,
        input  ram_data,
        input  ram_wr,
        input  busy,
        input  frame_done,
        input  error
    );

    modport slave (
        input  rx_data,
        input  rx_strobe,
        output ram_addr,
        output ram_data,
        output ram_wr,
        output busy,
        output frame_done,
        output error
    );
endinterface
`default_nettype wire

// File: rtl/framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : framebuffer_writer
// Purpose  : Parses 'L' (frame load) / 'P' (pixel write) commands from the
//            UART byte stream and drives the framebuffer write port.
//            Optional macro FB_WRITER_CHECKSUM_EN adds a trailing mod-256
//            checksum byte to frame loads.
// Revision : 1.0 - initial release
// ============================================================================
module framebuffer_writer #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 53200
) (
    input  logic                 clk_in,
    input  logic                 reset,
    framebuffer_writer_if.slave  bus
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] LOAD_DATA   = 3'd1;
    localparam logic [2:0] PIX_ADDR_HI = 3'd2;
    localparam logic [2:0] PIX_ADDR_LO = 3'd3;
    localparam logic [2:0] PIX_DATA_LO = 3'd4;
    localparam logic [2:0] PIX_DATA_HI = 3'd5;
    localparam logic [2:0] LOAD_CSUM   = 3'd6;

    localparam logic [7:0] c_cmd_load  = 8'h4C;
    localparam logic [7:0] c_cmd_pixel = 8'h50;
    // Pixel index bits carried by the high address byte (3 for a 4 KiB frame).
    localparam int         c_hi_bits   = ADDR_WIDTH - 9;
    localparam logic [TIMEOUT_WIDTH-1:0] c_gap_limit =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]               r_state;
    logic [ADDR_WIDTH-1:0]    r_byte_cnt;
    logic [ADDR_WIDTH-2:0]    r_pix_idx;
    logic [TIMEOUT_WIDTH-1:0] r_gap;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [7:0]               r_data;
    logic                     r_wr;
    logic                     r_frame_done;
    logic                     r_error;
`ifdef FB_WRITER_CHECKSUM_EN
    logic [7:0]               r_csum;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_pix_idx    <= '0;
            r_gap        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_wr         <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
`ifdef FB_WRITER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_wr         <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;

            if (bus.rx_strobe) begin
                // A strobe always beats the timeout, even on the threshold cycle.
                r_gap <= '0;
                case (r_state)
                    IDLE: begin
                        if (bus.rx_data == c_cmd_load) begin
                            r_state    <= LOAD_DATA;
                            r_byte_cnt <= '0;
`ifdef FB_WRITER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                        end else if (bus.rx_data == c_cmd_pixel) begin
                            r_state <= PIX_ADDR_HI;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    LOAD_DATA: begin
                        r_addr     <= r_byte_cnt;
                        r_data     <= bus.rx_data;
                        r_wr       <= 1'b1;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef FB_WRITER_CHECKSUM_EN
                        r_csum     <= r_csum + bus.rx_data;
                        if (&r_byte_cnt) begin
                            r_state <= LOAD_CSUM;
                        end
`else
                        if (&r_byte_cnt) begin
                            r_state      <= IDLE;
                            r_frame_done <= 1'b1;
                        end
`endif
                    end
                    PIX_ADDR_HI: begin
                        r_pix_idx[ADDR_WIDTH-2:8] <= bus.rx_data[c_hi_bits-1:0];
                        if (|bus.rx_data[7:c_hi_bits]) begin
                            r_state <= IDLE;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= PIX_ADDR_LO;
                        end
                    end
                    PIX_ADDR_LO: begin
                        r_pix_idx[7:0] <= bus.rx_data;
                        r_state        <= PIX_DATA_LO;
                    end
                    PIX_DATA_LO: begin
                        r_addr  <= {r_pix_idx, 1'b0};
                        r_data  <= bus.rx_data;
                        r_wr    <= 1'b1;
                        r_state <= PIX_DATA_HI;
                    end
                    PIX_DATA_HI: begin
                        r_addr  <= {r_pix_idx, 1'b1};
                        r_data  <= bus.rx_data;
                        r_wr    <= 1'b1;
                        r_state <= IDLE;
                    end
`ifdef FB_WRITER_CHECKSUM_EN
                    LOAD_CSUM: begin
                        if (bus.rx_data == r_csum) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end else if (r_state != IDLE) begin
                if (r_gap == c_gap_limit) begin
                    r_state <= IDLE;
                    r_error <= 1'b1;
                    r_gap   <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end else begin
                r_gap <= '0;
            end
        end
    end

    assign bus.ram_addr   = r_addr;
    assign bus.ram_data   = r_data;
    assign bus.ram_wr     = r_wr;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuffer_writer
// Purpose  : Directed self-checking bench for framebuffer_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_writer;

    localparam int ADDR_WIDTH     = 12;
    localparam int TIMEOUT_CYCLES = 53200;

    logic clk_in = 1'b0;
    logic reset;

    framebuffer_writer_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    framebuffer_writer #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT_WIDTH  (16),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every cycle passes through here, so pulse counters see each output cycle once.
    task automatic tick();
        @(negedge clk_in);
        if (bus.ram_wr === 1'b1)     wr_cnt++;
        if (bus.error === 1'b1)      err_cnt++;
        if (bus.frame_done === 1'b1) done_cnt++;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data   = b;
        bus.rx_strobe = 1'b1;
        tick();
        bus.rx_strobe = 1'b0;
        bus.rx_data   = 8'h00;
    endtask

    initial begin
        int w0;
        int e0;
        int d0;
        int bad;
        int k;
        bit seen;

        reset         = 1'b0;
        bus.rx_strobe = 1'b0;
        bus.rx_data   = 8'h00;

        // Reset held with random strobes
        for (int i = 0; i < 3; i++) begin
            bus.rx_strobe = 1'($urandom_range(0, 1));
            bus.rx_data   = 8'($urandom);
            tick();
        end
        bus.rx_strobe = 1'b0;
        check("rst_outputs", {20'd0, bus.ram_addr, bus.ram_data, bus.ram_wr, bus.busy,
                              bus.frame_done, bus.error}, 32'd0);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);

        reset = 1'b1;
        tick();
        e0 = err_cnt;
        w0 = wr_cnt;
        send(8'h00);
        check("bad_cmd_error", 32'(bus.error), 32'd1);
        check("bad_cmd_no_wr", 32'(bus.ram_wr), 32'd0);
        check("bad_cmd_idle", 32'(bus.busy), 32'd0);
        tick();
        check("bad_cmd_one_pulse", 32'(err_cnt - e0), 32'd1);
        check("bad_cmd_wr_total", 32'(wr_cnt - w0), 32'd0);

        // Full frame load, bytes 0x00..0xFF repeating
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'h4C);
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_cmd_no_wr", 32'(bus.ram_wr), 32'd0);
        w0  = wr_cnt;
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            send(8'(i));
            if (!(bus.ram_wr === 1'b1 && bus.ram_addr === 12'(i) && bus.ram_data === 8'(i)))
                bad++;
            if (i < 4095 && bus.frame_done !== 1'b0)
                bad++;
        end
        check("load_write_stream", 32'(bad), 32'd0);
        check("load_wr_count", 32'(wr_cnt - w0), 32'd4096);
`ifdef FB_WRITER_CHECKSUM_EN
        check("load_wait_csum", 32'(bus.frame_done), 32'd0);
        check("load_csum_busy", 32'(bus.busy), 32'd1);
        send(8'h00);
        check("csum_no_wr", 32'(bus.ram_wr), 32'd0);
`endif
        check("load_frame_done", 32'(bus.frame_done), 32'd1);
        check("load_idle_after", 32'(bus.busy), 32'd0);
        tick();
        check("load_done_once", 32'(done_cnt - d0), 32'd1);
        check("load_no_error", 32'(err_cnt - e0), 32'd0);

        // Single pixel write at index 0x7FF
        d0 = done_cnt;
        send(8'h50);
        send(8'h07);
        send(8'hFF);
        send(8'h34);
        check("pix_lo_wr", {bus.ram_wr, 3'd0, bus.ram_addr, bus.ram_data}, {1'b1, 3'd0, 12'hFFE, 8'h34});
        send(8'h12);
        check("pix_hi_wr", {bus.ram_wr, 3'd0, bus.ram_addr, bus.ram_data}, {1'b1, 3'd0, 12'hFFF, 8'h12});
        check("pix_idle", 32'(bus.busy), 32'd0);
        tick();
        check("pix_no_done", 32'(done_cnt - d0), 32'd0);

        // Out-of-range pixel high byte
        w0 = wr_cnt;
        send(8'h50);
        send(8'h08);
        check("pix_range_error", 32'(bus.error), 32'd1);
        check("pix_range_idle", 32'(bus.busy), 32'd0);
        tick();
        check("pix_range_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Byte-gap timeout inside a load
        e0 = err_cnt;
        send(8'h4C);
        w0 = wr_cnt;
        for (int j = 0; j < 10; j++) send(8'(8'h10 + j));
        check("to_busy_before", 32'(bus.busy), 32'd1);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < TIMEOUT_CYCLES + 10) begin
            tick();
            k++;
            if (bus.error === 1'b1) seen = 1'b1;
        end
        check("to_latency", 32'(k), 32'(TIMEOUT_CYCLES));
        check("to_busy_drop", 32'(bus.busy), 32'd0);
        tick();
        check("to_error_once", 32'(err_cnt - e0), 32'd1);
        check("to_wr_count", 32'(wr_cnt - w0), 32'd10);

        // Next load restarts at address 0
        send(8'h4C);
        send(8'hAA);
        check("reload_addr0", {bus.ram_wr, 3'd0, bus.ram_addr, bus.ram_data}, {1'b1, 3'd0, 12'h000, 8'hAA});

        // Reset on the 101st strobe of a load
        for (int j = 1; j < 100; j++) send(8'(j));
        check("mid_addr99", 32'(bus.ram_addr), 32'd99);
        bus.rx_data   = 8'h55;
        bus.rx_strobe = 1'b1;
        reset         = 1'b0;
        tick();
        bus.rx_strobe = 1'b0;
        check("mid_rst_no_wr", 32'(bus.ram_wr), 32'd0);
        check("mid_rst_idle", 32'(bus.busy), 32'd0);
        reset = 1'b1;
        tick();
        send(8'h00);
        check("post_rst_parse_idle", {bus.error, bus.ram_wr}, 32'd2);

`ifdef FB_WRITER_CHECKSUM_EN
        // Checksum mismatch: all 0x01 sums to 0x00, send 0x01
        tick();
        d0 = done_cnt;
        send(8'h4C);
        for (int i = 0; i < 4096; i++) send(8'h01);
        send(8'h01);
        check("csum_bad_error", 32'(bus.error), 32'd1);
        check("csum_bad_idle", 32'(bus.busy), 32'd0);
        tick();
        check("csum_bad_no_done", 32'(done_cnt - d0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
